// File: rtl/sobol_pkg.sv
// Shared definitions for the Sobol RNG and the stochastic multiplier run controller.
package sobol_pkg;

  // Default operand / RNG sample width; the run length is 2**INWD_DEF.
  localparam int INWD_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sc_cmp_unit.sv
// Unipolar stochastic multiply cell: two strict unsigned compares against RNG samples, ANDed.
module sc_cmp_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] rnd_a,
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] rnd_b,
  output logic         prod
);

  logic bit_a;
  logic bit_b;

  assign bit_a = (op_a > rnd_a);
  assign bit_b = (op_b > rnd_b);
  assign prod  = bit_a & bit_b;

endmodule

// File: rtl/sobol_mul_ctrl.sv
// Run controller: restarts the Sobol RNGs, runs one full period and counts product ones.
module sobol_mul_ctrl
  import sobol_pkg::*;
#(
  parameter int INWD = INWD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [INWD-1:0] opA,
  input  logic [INWD-1:0] opB,
  output logic            rng_clear,
  output logic            rng_enable,
  input  logic [INWD-1:0] rndA,
  input  logic [INWD-1:0] rndB,
  output logic            bs_out,
  output logic            bs_valid,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [INWD:0]   res
);

  state_t          state;
  state_t          state_next;
  logic [INWD-1:0] op_a_q;
  logic [INWD-1:0] op_b_q;
  logic [INWD-1:0] cnt;
  logic [INWD:0]   ones;
  logic            sv;
  logic            prod;

  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_valid) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      RUN:     if (cnt == '1) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt        <= '0;
      ones       <= '0;
      sv         <= 1'b0;
      rng_clear  <= 1'b0;
      rng_enable <= 1'b0;
    end else begin
      state      <= state_next;
      // Both RNG controls are registered from the next state so they line up with CLEAR / RUN.
      rng_clear  <= (state_next == CLEAR);
      rng_enable <= (state_next == RUN);
      sv         <= rng_enable;

      if (state == CLEAR) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;

      if (sv && prod) ones <= ones + 1'b1;

      if (state == IDLE && start_valid) begin
        op_a_q <= opA;
        op_b_q <= opB;
        ones   <= '0;
      end
    end
  end

  sc_cmp_unit #(
    .W (INWD)
  ) u_cmp (
    .op_a  (op_a_q),
    .rnd_a (rndA),
    .op_b  (op_b_q),
    .rnd_b (rndB),
    .prod  (prod)
  );

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign res         = ones;
  assign bs_valid    = sv;
  assign bs_out      = sv & prod;

endmodule

// File: tb/tb_sobol_mul_ctrl.sv
// Directed bench for sobol_mul_ctrl with a registered mock RNG (identity ramp or Sobol dim 1).
module tb_sobol_mul_ctrl;
  import sobol_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         rng_clear;
  logic         rng_enable;
  logic [W-1:0] rndA;
  logic [W-1:0] rndB;
  logic         bs_out;
  logic         bs_valid;
  logic         res_valid;
  logic         res_ready;
  logic [W:0]   res;

  int n_checks = 0;
  int n_errors = 0;

  logic         mode_sobol = 1'b0;
  logic [W-1:0] idx;
  logic [W-1:0] rnd;

  always #5 clk = ~clk;

  sobol_mul_ctrl #(
    .INWD (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .opA         (opA),
    .opB         (opB),
    .rng_clear   (rng_clear),
    .rng_enable  (rng_enable),
    .rndA        (rndA),
    .rndB        (rndB),
    .bs_out      (bs_out),
    .bs_valid    (bs_valid),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res         (res)
  );

  // Sobol dimension 1 is the bit-reversed Gray code of the index.
  function automatic logic [W-1:0] sobol1(input logic [W-1:0] n);
    logic [W-1:0] g;
    logic [W-1:0] r;
    g = n ^ (n >> 1);
    for (int i = 0; i < W; i++) r[i] = g[W-1-i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst || rng_clear) begin
      idx <= '0;
      rnd <= '0;
    end else if (rng_enable) begin
      rnd <= mode_sobol ? sobol1(idx) : idx;
      idx <= idx + 1'b1;
    end
  end

  assign rndA = rnd;
  assign rndB = rnd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run: start, wait for the result, optionally stall res_ready, then handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input logic [W:0] exp_res);
    int k;
    int lat;
    int nbs;
    int nclr;
    int nen;
    logic [W:0] held;
    @(negedge clk);
    check({tag, "_start_ready"}, start_ready, 1);
    opA = a;
    opB = b;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    opA = ~a;
    opB = ~b;
    k = 1; lat = -1; nbs = 0; nclr = 0; nen = 0;
    while (k <= 400) begin
      if (bs_valid) nbs++;
      if (rng_clear) nclr++;
      if (rng_enable) nen++;
      if (res_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, lat, 259);
    check({tag, "_bs_cycles"}, nbs, 256);
    check({tag, "_en_cycles"}, nen, 256);
    check({tag, "_clear_pulses"}, nclr, 1);
    check({tag, "_res"}, res, exp_res);
    held = res;
    for (int s = 0; s < stall; s++) begin
      start_valid = s[0];
      @(negedge clk);
      check({tag, "_stall_res"}, res, held);
      check({tag, "_stall_valid"}, res_valid, 1);
      check({tag, "_stall_start_ready"}, start_ready, 0);
      check({tag, "_stall_enable"}, rng_enable, 0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_idle_after"}, start_ready, 1);
    check({tag, "_valid_after"}, res_valid, 0);
  endtask

  initial begin
    int k;
    int t1;
    int t2;
    logic [W:0] r1;
    logic [W:0] r2;
    int nen;

    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b0;
    opA = '0;
    opB = '0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_rng_clear", rng_clear, 0);
    check("rst_rng_enable", rng_enable, 0);
    check("rst_bs_out", bs_out, 0);
    check("rst_bs_valid", bs_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res", res, 0);
    rst = 1'b0;

    run_op("sweep", 8'd128, 8'd255, 0, 9'd128);
    run_op("zero", 8'd0, 8'd200, 0, 9'd0);
    run_op("full", 8'd255, 8'd255, 0, 9'd255);
    mode_sobol = 1'b1;
    run_op("sobol", 8'd64, 8'd192, 0, 9'd64);
    mode_sobol = 1'b0;
    run_op("stall", 8'd100, 8'd255, 5, 9'd100);

    // Reset in the middle of RUN discards the run.
    @(negedge clk);
    opA = 8'd128;
    opB = 8'd255;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    nen = 0;
    for (int i = 0; i < 200 && nen < 50; i++) begin
      if (rng_enable) nen++;
      if (nen < 50) @(negedge clk);
    end
    check("mid_reached_run", nen, 50);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_start_ready", start_ready, 1);
    check("mid_rst_enable", rng_enable, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res", res, 0);
    rst = 1'b0;
    run_op("after_rst", 8'd32, 8'd255, 0, 9'd32);

    // Back-to-back runs with both handshakes held high.
    @(negedge clk);
    res_ready = 1'b1;
    opA = 8'd128;
    opB = 8'd255;
    start_valid = 1'b1;
    @(negedge clk);
    k = 1; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    while (k <= 700 && t2 < 0) begin
      if (k == 2) opA = 8'd32;
      if (res_valid) begin
        if (t1 < 0) begin
          t1 = k;
          r1 = res;
        end else begin
          t2 = k;
          r2 = res;
          start_valid = 1'b0;
        end
      end
      if (t2 < 0) begin
        @(negedge clk);
        k++;
      end
    end
    check("b2b_first_latency", t1, 259);
    check("b2b_spacing", t2 - t1, 260);
    check("b2b_first_res", r1, 128);
    check("b2b_second_res", r2, 32);
    @(negedge clk);
    res_ready = 1'b0;
    check("b2b_idle", start_ready, 1);
    @(negedge clk);
    check("b2b_no_third_run", start_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
